dot_product_unit: RTL and testbench

Pipelined dot-product reducer sitting directly downstream of the instruction decoder and the PE lane array. Each cycle it takes the per-lane multiply results, reduces them through a registered adder tree, and either accumulates the scalar into a running sum (dot-product accumulate) or completes the sum and shifts it into a LANES-wide result vector (dot-product shift). The result vector feeds the BRAM write mux, selected when `r_select`=1.

---
 rtl/dot_product_unit_pkg.sv | 25 ++
 rtl/dot_product_unit_adder_tree.sv | 83 ++++++++
 rtl/dot_product_unit.sv | 110 +++++++++++
 tb/tb_dot_product_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_unit_pkg.sv
// Shared constants for the dot-product reducer and its neighbours.
//   DP_LANES / DP_DATA_WIDTH : default vector geometry
//   DP_LATENCY               : issue edge to dp_out_valid pulse, in cycles
//   OPCODE_WIDTH / OP_SEL_WIDTH : decoder field widths used elsewhere
package dot_product_unit_pkg;

    localparam int DP_LANES      = 8;
    localparam int DP_DATA_WIDTH = 32;
    localparam int OPCODE_WIDTH  = 4;
    localparam int OP_SEL_WIDTH  = 2;

    // Input register + log2(LANES) tree levels + accumulate stage.
    function automatic int dp_latency(input int lanes);
        return $clog2(lanes) + 2;
    endfunction

    localparam int DP_LATENCY = dp_latency(DP_LANES);

    // Meaning of the decoder shift bit as it travels down the pipe.
    typedef enum logic {
        DP_OP_ACC   = 1'b0,
        DP_OP_SHIFT = 1'b1
    } dp_op_e;

endpackage

// File: rtl/dot_product_unit_adder_tree.sv
// Pipelined pairwise reduction of LANES operands, one registered level per
// tree level (latency log2(LANES)). A valid bit and a one-bit flag travel
// alongside the data.
//   clk, rst       : clock, synchronous active-high reset (sideband only)
//   in_valid/flag  : sideband entering level 1
//   in_data        : lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/flag : sideband leaving the last level
//   out_sum        : wrap-around sum of all lanes
//   stage_vld      : valid bit of every level, for busy
module adder_tree #(
    parameter int LANES      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_flag,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    output logic                          out_flag,
    output logic [DATA_WIDTH-1:0]         out_sum,
    output logic [$clog2(LANES)-1:0]      stage_vld
);
    localparam int DEPTH = $clog2(LANES);

    logic [DEPTH-1:0] vld_d, vld_q;
    logic [DEPTH-1:0] flag_d, flag_q;

    always_comb begin
        vld_d[0]  = in_valid;
        flag_d[0] = in_flag;
        for (int l = 1; l < DEPTH; l++) begin
            vld_d[l]  = vld_q[l-1];
            flag_d[l] = flag_q[l-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            flag_q <= '0;
        end else begin
            vld_q  <= vld_d;
            flag_q <= flag_d;
        end
    end

    for (genvar l = 0; l < DEPTH; l++) begin : g_lvl
        localparam int N = LANES >> (l + 1);

        logic [2*N*DATA_WIDTH-1:0] in_vec;
        logic [N*DATA_WIDTH-1:0]   sum_d, sum_q;

        if (l == 0) begin : g_first
            assign in_vec = in_data;
        end else begin : g_next
            assign in_vec = g_lvl[l-1].sum_q;
        end

        always_comb begin
            sum_d = '0;
            for (int k = 0; k < N; k++) begin
                sum_d[k*DATA_WIDTH +: DATA_WIDTH] =
                    in_vec[(2*k)*DATA_WIDTH +: DATA_WIDTH] +
                    in_vec[(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Data only moves with its valid bit; no reset needed since the
        // sideband decides whether anything downstream looks at it.
        always_ff @(posedge clk) begin
            if (vld_d[l]) begin
                sum_q <= sum_d;
            end
        end
    end

    assign out_sum   = g_lvl[DEPTH-1].sum_q;
    assign out_valid = vld_q[DEPTH-1];
    assign out_flag  = flag_q[DEPTH-1];
    assign stage_vld = vld_q;

endmodule

// File: rtl/dot_product_unit.sv
// Dot-product reducer: registers the PE multiply results, reduces them in a
// pipelined adder tree, then either accumulates the scalar or completes it
// and shifts it into lane 0 of a LANES-wide result vector.
//   clk, rst      : clock, synchronous active-high reset
//   dp_valid      : accept prod_in this cycle
//   dp_shift      : 1 = complete and shift, 0 = accumulate (with dp_valid)
//   prod_in       : lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dp_out        : result vector, lane 0 newest
//   dp_out_valid  : one-cycle pulse after a shift updates dp_out
//   busy          : an accepted op is still in the input/tree pipeline
module dot_product_unit
    import dot_product_unit_pkg::*;
#(
    parameter int LANES      = DP_LANES,
    parameter int DATA_WIDTH = DP_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dp_valid,
    input  logic                        dp_shift,
    input  logic [LANES*DATA_WIDTH-1:0] prod_in,
    output logic [LANES*DATA_WIDTH-1:0] dp_out,
    output logic                        dp_out_valid,
    output logic                        busy
);
    localparam int DEPTH = $clog2(LANES);

    // Stage 0: input register
    logic                        s0_vld_d,   s0_vld_q;
    logic                        s0_shift_d, s0_shift_q;
    logic [LANES*DATA_WIDTH-1:0] s0_prod_d,  s0_prod_q;

    always_comb begin
        s0_vld_d   = dp_valid;
        s0_shift_d = dp_valid & dp_shift;
        s0_prod_d  = dp_valid ? prod_in : s0_prod_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld_q   <= 1'b0;
            s0_shift_q <= 1'b0;
        end else begin
            s0_vld_q   <= s0_vld_d;
            s0_shift_q <= s0_shift_d;
        end
        s0_prod_q <= s0_prod_d;
    end

    // Tree levels 1..DEPTH
    logic                  tree_vld;
    logic                  tree_flag;
    logic [DATA_WIDTH-1:0] tree_sum;
    logic [DEPTH-1:0]      tree_stage_vld;

    adder_tree #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s0_vld_q),
        .in_flag   (s0_shift_q),
        .in_data   (s0_prod_q),
        .out_valid (tree_vld),
        .out_flag  (tree_flag),
        .out_sum   (tree_sum),
        .stage_vld (tree_stage_vld)
    );

    // Accumulate / shift stage
    logic [DATA_WIDTH-1:0]             acc_d, acc_q;
    logic [DATA_WIDTH-1:0]             acc_sum;
    logic [LANES-1:0][DATA_WIDTH-1:0]  res_d, res_q;
    logic                              out_vld_d, out_vld_q;

    always_comb begin
        acc_sum   = acc_q + tree_sum;
        acc_d     = acc_q;
        res_d     = res_q;
        out_vld_d = 1'b0;
        if (tree_vld) begin
            if (dp_op_e'(tree_flag) == DP_OP_SHIFT) begin
                // Oldest result drops off the top lane.
                res_d     = {res_q[LANES-2:0], acc_sum};
                acc_d     = '0;
                out_vld_d = 1'b1;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            res_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            res_q     <= res_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign dp_out       = res_q;
    assign dp_out_valid = out_vld_q;
    assign busy         = s0_vld_q | (|tree_stage_vld);

endmodule

// File: tb/tb_dot_product_unit.sv
// Scoreboard bench for dot_product_unit: each shift op pushes the expected
// result vector and pulse cycle; the monitor pops on every dp_out_valid.
module tb_dot_product_unit;
    import dot_product_unit_pkg::*;

    localparam int LANES = DP_LANES;
    localparam int DW    = DP_DATA_WIDTH;
    localparam int VW    = LANES * DW;

    typedef logic [LANES-1:0][DW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          dp_valid;
    logic          dp_shift;
    logic [VW-1:0] prod_in;
    logic [VW-1:0] dp_out;
    logic          dp_out_valid;
    logic          busy;

    always #5 clk = ~clk;

    dot_product_unit #(
        .LANES      (LANES),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_valid     (dp_valid),
        .dp_shift     (dp_shift),
        .prod_in      (prod_in),
        .dp_out       (dp_out),
        .dp_out_valid (dp_out_valid),
        .busy         (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model
    vec_t          m_out = '0;
    logic [DW-1:0] m_acc = '0;
    vec_t          exp_q[$];
    int            cyc_q[$];

    function automatic vec_t splat(input logic [DW-1:0] x);
        vec_t v;
        for (int i = 0; i < LANES; i++) v[i] = x;
        return v;
    endfunction

    task automatic issue(input logic sh, input vec_t v);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) s = s + v[i];
        @(negedge clk);
        dp_valid = 1'b1;
        dp_shift = sh;
        prod_in  = v;
        if (sh) begin
            m_out = {m_out[LANES-2:0], m_acc + s};
            m_acc = '0;
            exp_q.push_back(m_out);
            // sampled at edge cyc+1; pulse visible after DP_LATENCY-1 more edges
            cyc_q.push_back(cyc + DP_LATENCY);
        end else begin
            m_acc = m_acc + s;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dp_valid = 1'b0;
            dp_shift = 1'($urandom);
            prod_in  = {LANES{$urandom}};
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (dp_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 1, 0);
            end else begin
                chk("dp_out", dp_out, exp_q.pop_front());
                chk("latency", cyc, cyc_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        rst      = 1'b1;
        dp_valid = 1'b0;
        dp_shift = 1'b0;
        prod_in  = '0;

        // Reset with dp_valid high: op must be ignored
        @(negedge clk);
        dp_valid = 1'b1;
        dp_shift = 1'b1;
        prod_in  = splat(32'd7);
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        dp_valid = 1'b0;
        @(negedge clk);
        chk("rst_dp_out", dp_out, '0);
        chk("rst_out_valid", dp_out_valid, 0);
        chk("rst_busy", busy, 0);

        // Single shift, lanes 1..8 -> 36
        for (int i = 0; i < LANES; i++) v[i] = DW'(i + 1);
        issue(1'b1, v);
        idle(1);
        chk("busy_inflight", busy, 1);
        idle(8);
        chk("busy_drained", busy, 0);
        e = '0;
        e[0] = 32'd36;
        chk("single_shift", dp_out, e);

        // Accumulate then shift -> 40
        issue(1'b0, splat(32'd2));
        issue(1'b1, splat(32'd3));
        idle(8);
        e[1] = 32'd36;
        e[0] = 32'd40;
        chk("acc_then_shift", dp_out, e);

        // Nine back-to-back shifts, sums 1..9
        for (int k = 1; k <= 9; k++) begin
            v = '0;
            v[0] = DW'(k);
            issue(1'b1, v);
        end
        idle(8);
        for (int i = 0; i < LANES; i++) e[i] = DW'(9 - i);
        chk("nine_shifts", dp_out, e);

        // Wrap-around
        v = '0;
        v[0] = 32'h7FFF_FFFF;
        v[1] = 32'h7FFF_FFFF;
        issue(1'b1, v);
        idle(8);
        chk("wrap_lane0", dp_out[DW-1:0], VW'(32'hFFFF_FFFE));

        // Bubbles: acc, 3 idle, acc, shift -> 24
        issue(1'b0, splat(32'd1));
        idle(3);
        issue(1'b0, splat(32'd1));
        issue(1'b1, splat(32'd1));
        idle(8);
        chk("bubble_lane0", dp_out[DW-1:0], VW'(32'd24));
        chk("bubble_busy", busy, 0);

        // Random mix
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < LANES; i++) v[i] = $urandom;
            issue($urandom_range(0, 2) == 0, v);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        issue(1'b1, splat(32'd0));
        idle(10);
        chk("random_final", dp_out, m_out);

        // Reset mid-flight: in-flight shift discarded
        issue(1'b1, splat(32'd5));
        idle(1);
        @(negedge clk);
        rst      = 1'b1;
        dp_valid = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        m_out = '0;
        m_acc = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_dp_out", dp_out, '0);
        chk("midrst_out_valid", dp_out_valid, 0);
        idle(8);
        chk("midrst_hold", dp_out, '0);

        // Normal operation after reset
        issue(1'b1, splat(32'd1));
        idle(10);
        chk("post_rst_lane0", dp_out, VW'(32'd8));
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
